// File: rtl/mem_stage_pkg.sv
// Shared widths, handshake FSM state encoding and counter helper for the swt16 memory stage.
package mem_stage_pkg;

  localparam int DMEM_ADDR_WIDTH = 12;
  localparam int DMEM_WORD_WIDTH = 16;
  localparam int IALU_WORD_WIDTH = 16;
  localparam int PC_WIDTH        = 12;
  localparam int PMEM_WORD_WIDTH = 16;
  localparam int REG_IDX_WIDTH   = 4;
  localparam int PERF_CNT_WIDTH  = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } hs_state_t;

  function automatic logic [PERF_CNT_WIDTH-1:0] sat_inc(input logic [PERF_CNT_WIDTH-1:0] v);
    return (v == {PERF_CNT_WIDTH{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge bus between the memory stage (master) and data memory (slave).
interface mem_stage_if;
  import mem_stage_pkg::*;

  logic                       dmem_req;
  logic                       dmem_we;
  logic [DMEM_ADDR_WIDTH-1:0] dmem_addr;
  logic [DMEM_WORD_WIDTH-1:0] dmem_wdata;
  logic                       dmem_ack;
  logic [DMEM_WORD_WIDTH-1:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_ack, dmem_rdata
  );

endinterface

// File: rtl/mem_stage_dmem_handshake_fsm.sv
// Request/stall/complete generation for one data-memory access at a time.
//   state   | meaning
//   ST_IDLE | no access outstanding; a new access requests immediately, zero-wait if acked
//   ST_WAIT | access issued but not yet acked; upstream held
module mem_stage_dmem_handshake_fsm
  import mem_stage_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic access,
  input  logic ack,
  output logic req,
  output logic stall,
  output logic complete
);

  hs_state_t state, state_nx;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    req      = 1'b0;
    stall    = 1'b0;
    complete = 1'b0;
    case (state)
      ST_IDLE: begin
        if (access) begin
          req = 1'b1;
          if (ack) begin
            complete = 1'b1;
          end else begin
            stall    = 1'b1;
            state_nx = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (access) begin
          req = 1'b1;
          if (ack) begin
            complete = 1'b1;
            state_nx = ST_IDLE;
          end else begin
            stall = 1'b1;
          end
        end else begin
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// swt16 memory stage: samples EX results, runs the data-memory handshake, feeds write-back.
// Optional performance counters are built when SWT16_MEM_PERF_CNT_EN is defined.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_act_load_dmem,
  input  logic                       in_act_store_dmem,
  input  logic                       in_act_write_res_to_reg,
  input  logic [DMEM_ADDR_WIDTH-1:0] in_dmem_rd_addr,
  input  logic [DMEM_ADDR_WIDTH-1:0] in_dmem_wr_addr,
  input  logic [DMEM_WORD_WIDTH-1:0] in_dmem_wr_word,
  input  logic [PMEM_WORD_WIDTH-1:0] in_instr,
  input  logic [PC_WIDTH-1:0]        in_pc,
  input  logic [IALU_WORD_WIDTH-1:0] in_res,
  input  logic [REG_IDX_WIDTH-1:0]   in_res_reg_idx,
  mem_stage_if.master                dmem,
`ifdef SWT16_MEM_PERF_CNT_EN
  output logic [PERF_CNT_WIDTH-1:0]  out_cnt_loads,
  output logic [PERF_CNT_WIDTH-1:0]  out_cnt_stores,
  output logic [PERF_CNT_WIDTH-1:0]  out_cnt_wait_cycles,
`endif
  output logic                       out_stall,
  output logic                       out_act_write_res_to_reg,
  output logic [IALU_WORD_WIDTH-1:0] out_res,
  output logic [REG_IDX_WIDTH-1:0]   out_res_reg_idx,
  output logic [PMEM_WORD_WIDTH-1:0] out_instr,
  output logic [PC_WIDTH-1:0]        out_pc
);

  logic                       ld_q, st_q, wr_q;
  logic [DMEM_ADDR_WIDTH-1:0] addr_q;
  logic [DMEM_WORD_WIDTH-1:0] wdata_q;
  logic [IALU_WORD_WIDTH-1:0] res_q;
  logic [REG_IDX_WIDTH-1:0]   idx_q;
  logic [PMEM_WORD_WIDTH-1:0] instr_q;
  logic [PC_WIDTH-1:0]        pc_q;

  logic access, is_load, fsm_req, fsm_stall, fsm_complete;

  // Only one address is ever needed, so the store/load choice is made at sample time.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ld_q    <= 1'b0;
      st_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      res_q   <= '0;
      idx_q   <= '0;
      instr_q <= '0;
      pc_q    <= '0;
    end else if (!fsm_stall) begin
      ld_q    <= in_act_load_dmem;
      st_q    <= in_act_store_dmem;
      wr_q    <= in_act_write_res_to_reg;
      addr_q  <= in_act_store_dmem ? in_dmem_wr_addr : in_dmem_rd_addr;
      wdata_q <= in_dmem_wr_word;
      res_q   <= in_res;
      idx_q   <= in_res_reg_idx;
      instr_q <= in_instr;
      pc_q    <= in_pc;
    end
  end

  assign access  = ld_q | st_q;
  assign is_load = ld_q & ~st_q;

  mem_stage_dmem_handshake_fsm u_hs (
    .clock    (clock),
    .reset    (reset),
    .access   (access),
    .ack      (dmem.dmem_ack),
    .req      (fsm_req),
    .stall    (fsm_stall),
    .complete (fsm_complete)
  );

  assign dmem.dmem_req   = fsm_req;
  assign dmem.dmem_we    = fsm_req & st_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_wdata = wdata_q;
  assign out_stall       = fsm_stall;

  // Write-back sees a bubble for every stalled cycle.
  always_comb begin
    out_act_write_res_to_reg = 1'b0;
    out_res                  = '0;
    out_res_reg_idx          = '0;
    out_instr                = '0;
    out_pc                   = '0;
    if (!fsm_stall) begin
      out_act_write_res_to_reg = wr_q & ~st_q;
      out_res                  = (is_load && fsm_complete) ? dmem.dmem_rdata : res_q;
      out_res_reg_idx          = idx_q;
      out_instr                = instr_q;
      out_pc                   = pc_q;
    end
  end

`ifdef SWT16_MEM_PERF_CNT_EN
  logic [PERF_CNT_WIDTH-1:0] cnt_loads_q, cnt_stores_q, cnt_wait_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_loads_q  <= '0;
      cnt_stores_q <= '0;
      cnt_wait_q   <= '0;
    end else begin
      if (fsm_complete &&  st_q) cnt_stores_q <= sat_inc(cnt_stores_q);
      if (fsm_complete && !st_q) cnt_loads_q  <= sat_inc(cnt_loads_q);
      if (fsm_stall)             cnt_wait_q   <= sat_inc(cnt_wait_q);
    end
  end

  assign out_cnt_loads       = cnt_loads_q;
  assign out_cnt_stores      = cnt_stores_q;
  assign out_cnt_wait_cycles = cnt_wait_q;
`endif

endmodule
